pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the multi-cycle CPU. It replaces the fixed 32-bit counter. Internally it selects the next PC: sequential, conditional branch, jump, or register target. It also provides a halt/resume state machine, misaligned-target trapping with a captured exception PC, and an update counter. It sits between the control unit (update strobe, next-PC select, halt/resume) and instruction memory (current address).

## Interface
Parameters:
- WIDTH, 32, address width in bits (≥ JUMP_BITS+6)
- IMM_BITS, 16, branch offset width (word offset, signed)
- JUMP_BITS, 26, jump target field width (word index)
- RESET_VECTOR, 0, PC value after reset (word aligned)
- TRAP_VECTOR, 32'h0000_0180, PC loaded on a misaligned register target
- COUNT_WIDTH, 32, update counter width

Ports:
- CLK_in  in  1  clock; all state changes on rising edge
- Start_en  in  1  reset; synchronous, active-low (0 = reset)
- Halt_en  in  1  request halt
- Resume_en  in  1  leave halt
- Write_en  in  1  PC update strobe (one cycle per instruction, from control FSM)
- Branch_en  in  1  branch condition true (used only when Sel_in = 01)
- Sel_in  in  2  next-PC source: 00 seq, 01 branch, 10 jump, 11 register
- Imm_in  in  IMM_BITS  signed branch word offset
- Target_in  in  JUMP_BITS  jump word index
- Reg_in  in  WIDTH  register target (byte address)
- Address_out  out  WIDTH  current PC (registered)
- Address_plus_out  out  WIDTH  Address_out + 4 (combinational)
- Halted_out  out  1  1 while in HALT
- Misalign_out  out  1  one-cycle pulse on trap
- Epc_out  out  WIDTH  PC of instruction whose target trapped
- Count_out  out  COUNT_WIDTH  number of accepted updates, wraps

## Operation
- Next-PC calculation (all arithmetic modulo 2^WIDTH):
  - seq: pc+4.
  - branch: pc+4 + (sign_extend(Imm_in) << 2) if Branch_en, else pc+4.
  - jump: {pc+4[WIDTH-1:JUMP_BITS+2], Target_in, 2'b00}.
  - register: Reg_in.
- Misaligned target: Sel_in = 11 with Reg_in[1:0] ≠ 0 on an accepted update:
  - PC ← TRAP_VECTOR, Epc_out ← current PC, Misalign_out = 1 for the next cycle.
  - Count still increments.
- FSM states RUN and HALT:
  - RUN: Halt_en = 1 → HALT. The update in that cycle is discarded; halt wins over Write_en.
  - RUN: otherwise, Write_en = 1 → accept the update.
  - HALT: PC, count and Epc_out are frozen, and Write_en is ignored.
  - HALT: Resume_en = 1 and Halt_en = 0 → RUN. No update is accepted in the resume cycle.
  - HALT: Halt_en and Resume_en both 1 → stay in HALT.
- Reset (Start_en = 0) overrides everything and may arrive mid-halt or mid-trap:
  - state RUN, Address_out = RESET_VECTOR, Epc_out = 0, Count_out = 0.
  - Misalign_out = 0, Halted_out = 0.

## Timing
- Update latency: 1 cycle. An accepted update on edge N gives the new Address_out after edge N.
- Address_plus_out follows Address_out combinationally, same cycle.
- Halted_out is registered and asserts the cycle after the Halt_en edge.
- Misalign_out is registered; it is high exactly the one cycle after the trapping edge.
- Counter wrap: all-ones + 1 → 0.
- PC wrap: pc = 2^WIDTH−4 with seq → 0.

## Structure
- Shared package cpu_pkg holds:
  - next-PC select encodings PC_SEQ/PC_BRANCH/PC_JUMP/PC_REG;
  - the FSM state type (RUN/HALT);
  - the default vectors RESET_VECTOR/TRAP_VECTOR.
- One sub-module is natural: pc_next_calc. It is combinational, taking pc, Sel_in, Branch_en, Imm_in, Target_in and Reg_in, and producing next_pc and misalign.
- The top level holds the FSM, PC/EPC/count registers and the trap mux.

## Test plan
- Reset, then 3 updates with Sel = 00 → Address_out 0, 4, 8, 12; Count_out = 3; Address_plus_out = 16.
- pc = 0x40, Sel = 01, Imm = 0xFFFE, Branch_en = 1 → pc = 0x3C.
- Same pc, Branch_en = 0 → pc = 0x44.
- pc = 0x1000_0000, Sel = 10, Target = 0x000_0100 → 0x1000_0400.
- Sel = 11, Reg_in = 0x0000_2002 at pc = 0x80:
  - pc = TRAP_VECTOR, Epc_out = 0x80, Misalign_out high exactly one cycle;
  - Reg_in = 0x2000 instead → pc = 0x2000 with no pulse.
- Halt_en with Write_en in the same cycle → no update, Halted_out = 1; 5 Write_en pulses are ignored; Resume_en returns to RUN and the next Write_en advances by 4.
- Start_en = 0 during HALT after a trap → all outputs at reset values on the next edge. Pc = 0xFFFF_FFFC with seq → 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU program-counter path: next-PC select codes,
// sequencer FSM state type and the default reset/trap vectors.
package cpu_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG    = 2'b11
    } pc_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0180;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit / instruction-memory side of the PC sequencer.
// master = control unit, slave = sequencer.
interface pc_sequencer_if #(
    parameter int WIDTH       = 32,
    parameter int IMM_BITS    = 16,
    parameter int JUMP_BITS   = 26,
    parameter int COUNT_WIDTH = 32
);
    logic                   Halt_en;
    logic                   Resume_en;
    logic                   Write_en;
    logic                   Branch_en;
    logic [1:0]             Sel_in;
    logic [IMM_BITS-1:0]    Imm_in;
    logic [JUMP_BITS-1:0]   Target_in;
    logic [WIDTH-1:0]       Reg_in;
    logic [WIDTH-1:0]       Address_out;
    logic [WIDTH-1:0]       Address_plus_out;
    logic                   Halted_out;
    logic                   Misalign_out;
    logic [WIDTH-1:0]       Epc_out;
    logic [COUNT_WIDTH-1:0] Count_out;

    modport master (
        output Halt_en, Resume_en, Write_en, Branch_en, Sel_in,
               Imm_in, Target_in, Reg_in,
        input  Address_out, Address_plus_out, Halted_out, Misalign_out,
               Epc_out, Count_out
    );

    modport slave (
        input  Halt_en, Resume_en, Write_en, Branch_en, Sel_in,
               Imm_in, Target_in, Reg_in,
        output Address_out, Address_plus_out, Halted_out, Misalign_out,
               Epc_out, Count_out
    );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, conditional branch, jump or
// register target, plus misaligned register-target detection.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMM_BITS  = 16,
    parameter int JUMP_BITS = 26
) (
    input  logic [WIDTH-1:0]     i_pc,
    input  logic [1:0]           i_sel,
    input  logic                 i_branch_en,
    input  logic [IMM_BITS-1:0]  i_imm,
    input  logic [JUMP_BITS-1:0] i_target,
    input  logic [WIDTH-1:0]     i_reg,
    output logic [WIDTH-1:0]     o_next_pc,
    output logic                 o_misalign
);

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_imm_ext;
    logic [WIDTH-1:0] w_branch_pc;
    logic [WIDTH-1:0] w_jump_pc;

    assign w_pc_plus4  = i_pc + WIDTH'(4);
    assign w_imm_ext   = {{(WIDTH-IMM_BITS){i_imm[IMM_BITS-1]}}, i_imm};
    assign w_branch_pc = w_pc_plus4 + (w_imm_ext << 2);
    // Jump keeps the region bits of pc+4 and replaces the word index.
    assign w_jump_pc   = {w_pc_plus4[WIDTH-1:JUMP_BITS+2], i_target, 2'b00};

    always_comb begin
        o_next_pc  = w_pc_plus4;
        o_misalign = 1'b0;
        case (pc_sel_e'(i_sel))
            PC_SEQ:    o_next_pc = w_pc_plus4;
            PC_BRANCH: o_next_pc = i_branch_en ? w_branch_pc : w_pc_plus4;
            PC_JUMP:   o_next_pc = w_jump_pc;
            PC_REG: begin
                o_next_pc  = i_reg;
                o_misalign = (i_reg[1:0] != 2'b00);
            end
            default:   o_next_pc = w_pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/HALT control, PC/EPC/update-count registers
// and the misaligned-target trap mux.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | Write_en accepts a PC update; Halt_en enters halt (wins)
// ST_HALT | PC, count, EPC frozen; Resume_en (without Halt_en) returns
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int                   WIDTH        = 32,
    parameter int                   IMM_BITS     = 16,
    parameter int                   JUMP_BITS    = 26,
    parameter logic [WIDTH-1:0]     RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0]     TRAP_VECTOR  = WIDTH'(DEFAULT_TRAP_VECTOR),
    parameter int                   COUNT_WIDTH  = 32
) (
    input  logic          CLK_in,
    input  logic          Start_en,
    pc_sequencer_if.slave bus
);

    seq_state_e             r_state;
    seq_state_e             w_state_nxt;
    logic                   w_accept;
    logic [WIDTH-1:0]       r_pc;
    logic [WIDTH-1:0]       r_epc;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_misalign;
    logic                   r_halted;
    logic [WIDTH-1:0]       w_next_pc;
    logic                   w_misalign;

    pc_next_calc #(
        .WIDTH     (WIDTH),
        .IMM_BITS  (IMM_BITS),
        .JUMP_BITS (JUMP_BITS)
    ) u_next_calc (
        .i_pc        (r_pc),
        .i_sel       (bus.Sel_in),
        .i_branch_en (bus.Branch_en),
        .i_imm       (bus.Imm_in),
        .i_target    (bus.Target_in),
        .i_reg       (bus.Reg_in),
        .o_next_pc   (w_next_pc),
        .o_misalign  (w_misalign)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.Halt_en) begin
                    w_state_nxt = ST_HALT;
                end else if (bus.Write_en) begin
                    w_accept = 1'b1;
                end
            end
            ST_HALT: begin
                if (bus.Resume_en && !bus.Halt_en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK_in) begin
        if (!Start_en) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_VECTOR;
            r_epc      <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_halted   <= (w_state_nxt == ST_HALT);
            r_misalign <= 1'b0;
            if (w_accept) begin
                r_count <= r_count + COUNT_WIDTH'(1);
                // A trapping update still counts as an accepted update.
                if (w_misalign) begin
                    r_pc       <= TRAP_VECTOR;
                    r_epc      <= r_pc;
                    r_misalign <= 1'b1;
                end else begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

    assign bus.Address_out      = r_pc;
    assign bus.Address_plus_out = r_pc + WIDTH'(4);
    assign bus.Halted_out       = r_halted;
    assign bus.Misalign_out     = r_misalign;
    assign bus.Epc_out          = r_epc;
    assign bus.Count_out        = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values; a second
// instance with a 3-bit counter covers counter wrap.
module tb_pc_sequencer;

    logic clk_sys = 1'b0;
    logic start_en;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_sys = ~clk_sys;

    pc_sequencer_if #(.COUNT_WIDTH(32)) bus ();
    pc_sequencer_if #(.COUNT_WIDTH(3))  bus2 ();

    pc_sequencer #(.COUNT_WIDTH(32)) dut (
        .CLK_in   (clk_sys),
        .Start_en (start_en),
        .bus      (bus.slave)
    );

    pc_sequencer #(.COUNT_WIDTH(3)) dut2 (
        .CLK_in   (clk_sys),
        .Start_en (start_en),
        .bus      (bus2.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic upd(input logic [1:0] sel, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] rin,
                       input logic br);
        bus.Sel_in    = sel;
        bus.Imm_in    = imm;
        bus.Target_in = tgt;
        bus.Reg_in    = rin;
        bus.Branch_en = br;
        bus.Write_en  = 1'b1;
        step();
        bus.Write_en  = 1'b0;
    endtask

    initial begin
        start_en       = 1'b0;
        bus.Halt_en    = 1'b0;
        bus.Resume_en  = 1'b0;
        bus.Write_en   = 1'b0;
        bus.Branch_en  = 1'b0;
        bus.Sel_in     = 2'b00;
        bus.Imm_in     = '0;
        bus.Target_in  = '0;
        bus.Reg_in     = '0;
        bus2.Halt_en   = 1'b0;
        bus2.Resume_en = 1'b0;
        bus2.Write_en  = 1'b0;
        bus2.Branch_en = 1'b0;
        bus2.Sel_in    = 2'b00;
        bus2.Imm_in    = '0;
        bus2.Target_in = '0;
        bus2.Reg_in    = '0;

        step();
        step();
        chk("rst_pc",       bus.Address_out, 64'h0);
        chk("rst_count",    bus.Count_out, 64'h0);
        chk("rst_halted",   bus.Halted_out, 64'h0);
        chk("rst_misalign", bus.Misalign_out, 64'h0);
        chk("rst_epc",      bus.Epc_out, 64'h0);
        start_en = 1'b1;
        step();
        chk("idle_pc", bus.Address_out, 64'h0);

        for (int i = 1; i <= 3; i++) begin
            upd(2'b00, 16'h0, 26'h0, 32'h0, 1'b0);
            chk("seq_pc", bus.Address_out, 64'(4 * i));
        end
        chk("seq_count", bus.Count_out, 64'd3);
        chk("seq_plus",  bus.Address_plus_out, 64'h10);

        upd(2'b11, 16'h0, 26'h0, 32'h40, 1'b0);
        upd(2'b01, 16'hFFFE, 26'h0, 32'h0, 1'b1);
        chk("branch_taken", bus.Address_out, 64'h3C);
        upd(2'b11, 16'h0, 26'h0, 32'h40, 1'b0);
        upd(2'b01, 16'hFFFE, 26'h0, 32'h0, 1'b0);
        chk("branch_not_taken", bus.Address_out, 64'h44);

        upd(2'b11, 16'h0, 26'h0, 32'h1000_0000, 1'b0);
        upd(2'b10, 16'h0, 26'h000_0100, 32'h0, 1'b0);
        chk("jump_pc", bus.Address_out, 64'h1000_0400);

        upd(2'b11, 16'h0, 26'h0, 32'h80, 1'b0);
        upd(2'b11, 16'h0, 26'h0, 32'h2002, 1'b0);
        chk("trap_pc",       bus.Address_out, 64'h180);
        chk("trap_epc",      bus.Epc_out, 64'h80);
        chk("trap_pulse",    bus.Misalign_out, 64'h1);
        chk("trap_count",    bus.Count_out, 64'd11);
        step();
        chk("trap_pulse_end", bus.Misalign_out, 64'h0);

        upd(2'b11, 16'h0, 26'h0, 32'h80, 1'b0);
        upd(2'b11, 16'h0, 26'h0, 32'h2000, 1'b0);
        chk("reg_pc",       bus.Address_out, 64'h2000);
        chk("reg_no_pulse", bus.Misalign_out, 64'h0);
        chk("reg_epc_hold", bus.Epc_out, 64'h80);

        bus.Sel_in   = 2'b00;
        bus.Halt_en  = 1'b1;
        bus.Write_en = 1'b1;
        step();
        bus.Halt_en  = 1'b0;
        chk("halt_pc",     bus.Address_out, 64'h2000);
        chk("halt_halted", bus.Halted_out, 64'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_ignore_pc", bus.Address_out, 64'h2000);
        end
        chk("halt_count", bus.Count_out, 64'd13);
        bus.Halt_en   = 1'b1;
        bus.Resume_en = 1'b1;
        step();
        chk("halt_resume_both", bus.Halted_out, 64'h1);
        bus.Halt_en   = 1'b0;
        step();
        bus.Resume_en = 1'b0;
        bus.Write_en  = 1'b0;
        chk("resume_halted", bus.Halted_out, 64'h0);
        chk("resume_pc",     bus.Address_out, 64'h2000);
        upd(2'b00, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("resume_adv_pc", bus.Address_out, 64'h2004);
        chk("resume_count",  bus.Count_out, 64'd14);

        upd(2'b11, 16'h0, 26'h0, 32'h0000_0003, 1'b0);
        chk("trap2_epc", bus.Epc_out, 64'h2004);
        bus.Halt_en = 1'b1;
        step();
        chk("trap2_halted", bus.Halted_out, 64'h1);
        start_en = 1'b0;
        step();
        bus.Halt_en = 1'b0;
        chk("mid_rst_pc",       bus.Address_out, 64'h0);
        chk("mid_rst_epc",      bus.Epc_out, 64'h0);
        chk("mid_rst_count",    bus.Count_out, 64'h0);
        chk("mid_rst_halted",   bus.Halted_out, 64'h0);
        chk("mid_rst_misalign", bus.Misalign_out, 64'h0);
        start_en = 1'b1;

        upd(2'b11, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_plus", bus.Address_plus_out, 64'h0);
        upd(2'b00, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("wrap_pc", bus.Address_out, 64'h0);

        bus2.Write_en = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("cnt3_full", bus2.Count_out, 64'd7);
        step();
        bus2.Write_en = 1'b0;
        chk("cnt3_wrap",    bus2.Count_out, 64'd0);
        chk("cnt3_pc",      bus2.Address_out, 64'h20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
